// File: rtl/fetch_pkg.sv
// Shared widths, word/instruction types and buffer entry layout for the fetch unit.
package fetch_pkg;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DATA_W = 32;

  typedef logic [ADDR_W-1:0] waddr_t;
  typedef logic [DATA_W-1:0] instr_t;

  typedef struct packed {
    instr_t instr;
    waddr_t pc;
  } fetch_entry_t;

  // Word address increment; wraps 2047 -> 0 through the natural 11-bit overflow.
  function automatic waddr_t pc_inc(input waddr_t pc);
    return pc + waddr_t'(1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: circular FIFO with synchronous flush and simultaneous push/pop when full.
module fetch_fifo #(
  parameter int unsigned  WIDTH = 43,
  parameter int unsigned  DEPTH = 2,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd;
  logic [PTR_W-1:0] r_wr;
  logic [CNT_W-1:0] r_count;
  logic             w_pop;
  logic             w_push;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_pop  = i_pop & (r_count != '0);
  // A full buffer still takes a push when the head leaves in the same cycle.
  assign w_push = i_push & ((r_count != CNT_W'(DEPTH)) | w_pop);

  always_ff @(posedge clk) begin
    if (!resetn || i_flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= ptr_inc(r_wr);
      if (w_pop)  r_rd <= ptr_inc(r_rd);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && !i_flush && w_push) r_mem[r_wr] <= i_data;
  end

  assign o_valid = (r_count != '0);
  assign o_data  = r_mem[r_rd];
  assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: 1-cycle-latency memory, tagged in-flight request, buffered decode handshake.
// Optional build macro FETCH_BYPASS_EN forwards the memory response straight to decode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter waddr_t      RESET_PC  = 11'd0,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic   clk,
  input  logic   resetn,
  input  logic   redirect_valid,
  input  waddr_t redirect_pc,
  output logic   mem_r_en,
  output waddr_t mem_r_adrs,
  input  instr_t mem_data,
  output logic   if_valid,
  input  logic   if_ready,
  output instr_t if_instr,
  output waddr_t if_pc
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

  waddr_t           r_pc;
  waddr_t           r_tag;
  logic             r_inflight;
  logic             w_resp;
  logic             w_push;
  logic             w_pop;
  logic             w_valid;
  logic             w_issue;
  logic             w_head_valid;
  logic [CNT_W-1:0] w_count;
  fetch_entry_t     w_head;
  fetch_entry_t     w_resp_entry;
  fetch_entry_t     w_out;
  int               w_occ;

  // A redirect in the response cycle drops the word: flush wins over push.
  assign w_resp       = resetn & r_inflight & ~redirect_valid;
  assign w_resp_entry = '{instr: mem_data, pc: r_tag};

`ifdef FETCH_BYPASS_EN
  logic w_byp;
  assign w_byp   = w_resp & ~w_head_valid;
  assign w_valid = w_head_valid | w_byp;
  assign w_out   = w_head_valid ? w_head : w_resp_entry;
  // A bypassed word taken by decode this cycle never enters the buffer.
  assign w_push  = w_resp & ~(w_byp & if_ready);
`else
  assign w_valid = w_head_valid;
  assign w_out   = w_head;
  assign w_push  = w_resp;
`endif

  assign w_pop   = w_valid & if_ready;
  assign w_occ   = int'(w_count) + int'(r_inflight) - int'(w_pop);
  assign w_issue = resetn & ~redirect_valid & (w_occ < int'(BUF_DEPTH));

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_flush (redirect_valid),
    .i_push  (w_push),
    .i_data  (w_resp_entry),
    .i_pop   (w_head_valid & if_ready),
    .o_valid (w_head_valid),
    .o_data  (w_head),
    .o_count (w_count)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_pc       <= RESET_PC;
      r_tag      <= '0;
      r_inflight <= 1'b0;
    end else if (redirect_valid) begin
      r_pc       <= redirect_pc;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_tag <= r_pc;
        r_pc  <= pc_inc(r_pc);
      end
    end
  end

  assign mem_r_en   = w_issue;
  assign mem_r_adrs = w_issue ? r_pc : '0;
  assign if_valid   = resetn & w_valid;
  assign if_instr   = resetn ? w_out.instr : '0;
  assign if_pc      = resetn ? w_out.pc : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed table, corner sequences, randomized run vs queue model.
module tb_fetch_unit;

  localparam logic [10:0] RST_PC = 11'd0;
  localparam int          DEPTH  = 2;
`ifdef FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        redirect_valid;
  logic [10:0] redirect_pc;
  logic        mem_r_en;
  logic [10:0] mem_r_adrs;
  logic [31:0] mem_data = '0;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [10:0] if_pc;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC  (RST_PC),
    .BUF_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_r_en       (mem_r_en),
    .mem_r_adrs     (mem_r_adrs),
    .mem_data       (mem_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc)
  );

  function automatic logic [31:0] word(input logic [10:0] a);
    return 32'h0000_00A0 + {21'd0, a};
  endfunction

  // Instruction memory: data for a request appears the next cycle, garbage otherwise.
  always @(posedge clk) mem_data <= mem_r_en ? word(mem_r_adrs) : 32'hDEAD_BEEF;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: outstanding requests in order, each usable LAT cycles after issue.
  typedef struct {
    logic [10:0] pc;
    int          rdy;
  } req_t;

  req_t        q[$];
  logic [10:0] m_pc = RST_PC;
  int          cyc  = 0;
  logic        m_valid;
  logic        m_pop;
  logic        m_en;

  always @(negedge clk) begin : model
    if (!resetn) begin
      chk("rst_en", 32'(mem_r_en), 32'd0);
      chk("rst_adrs", 32'(mem_r_adrs), 32'd0);
      chk("rst_valid", 32'(if_valid), 32'd0);
      chk("rst_instr", if_instr, 32'd0);
      chk("rst_pc", 32'(if_pc), 32'd0);
      q.delete();
      m_pc = RST_PC;
    end else if (redirect_valid) begin
      chk("redir_en", 32'(mem_r_en), 32'd0);
      q.delete();
      m_pc = redirect_pc;
    end else begin
      m_valid = (q.size() > 0) && (q[0].rdy <= cyc);
      chk("m_valid", 32'(if_valid), 32'(m_valid));
      if (m_valid) begin
        chk("m_pc", 32'(if_pc), 32'(q[0].pc));
        chk("m_instr", if_instr, word(q[0].pc));
      end
      m_pop = m_valid && if_ready;
      m_en  = (int'(q.size()) - int'(m_pop)) < DEPTH;
      chk("m_en", 32'(mem_r_en), 32'(m_en));
      if (m_en) chk("m_adrs", 32'(mem_r_adrs), 32'(m_pc));
      if (m_pop) void'(q.pop_front());
      if (m_en) begin
        q.push_back('{pc: m_pc, rdy: cyc + LAT});
        m_pc = m_pc + 11'd1;
      end
    end
    cyc++;
  end

  // Wait (bounded) for the next accepted word and compare it with the expected address.
  task automatic take(input string nm, input logic [10:0] pc);
    bit got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (if_valid && if_ready) begin
        got = 1'b1;
        chk(nm, 32'(if_pc), 32'(pc));
        chk({nm, "_instr"}, if_instr, word(pc));
      end
      tick();
    end
    if (!got) begin
      n_checks++;
      n_errs++;
      $display("FAIL %s: no word accepted within 8 cycles, expected pc %0d", nm, pc);
    end
  endtask

  typedef struct {
    logic        ready;
    logic        exp_en;
    logic [10:0] exp_adrs;
    logic        exp_valid;
    logic [10:0] exp_pc;
  } vec_t;

  vec_t tv[8];

  initial begin
    bit got;
    for (int i = 0; i < 8; i++) begin
      tv[i].ready     = 1'b1;
      tv[i].exp_en    = 1'b1;
      tv[i].exp_adrs  = 11'(i);
      tv[i].exp_valid = (i >= LAT);
      tv[i].exp_pc    = 11'(i - LAT);
    end

    resetn         = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if_ready       = 1'b1;
    repeat (3) tick();

    // Reset release streaming: consecutive addresses, valid after LAT cycles, no gaps.
    resetn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if_ready = tv[i].ready;
      @(negedge clk);
      chk("tab_en", 32'(mem_r_en), 32'(tv[i].exp_en));
      chk("tab_adrs", 32'(mem_r_adrs), 32'(tv[i].exp_adrs));
      chk("tab_valid", 32'(if_valid), 32'(tv[i].exp_valid));
      if (tv[i].exp_valid) begin
        chk("tab_pc", 32'(if_pc), 32'(tv[i].exp_pc));
        chk("tab_instr", if_instr, word(tv[i].exp_pc));
      end
      tick();
    end

    // Decode stall: head held, fetch stops, then drains in order.
    resetn = 1'b0;
    tick();
    resetn   = 1'b1;
    if_ready = 1'b0;
    got      = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (if_valid) got = 1'b1;
      tick();
    end
    if (!got) begin
      n_checks++;
      n_errs++;
      $display("FAIL stall_first: if_valid never rose, expected within 8 cycles");
    end
    repeat (5) begin
      @(negedge clk);
      chk("stall_instr", if_instr, word(11'd0));
      chk("stall_en", 32'(mem_r_en), 32'd0);
      tick();
    end
    if_ready = 1'b1;
    take("drain0", 11'd0);
    take("drain1", 11'd1);
    take("drain2", 11'd2);

    // Redirect while streaming with a request in flight.
    redirect_valid = 1'b1;
    redirect_pc    = 11'd100;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("redir_flush", 32'(if_valid), 32'd0);
    tick();
    take("redir100", 11'd100);

    // Redirect near the top of the address space: wrap.
    redirect_valid = 1'b1;
    redirect_pc    = 11'd2046;
    tick();
    redirect_valid = 1'b0;
    take("wrap0", 11'd2046);
    take("wrap1", 11'd2047);
    take("wrap2", 11'd0);
    take("wrap3", 11'd1);

    // One-cycle reset mid-stream.
    tick();
    resetn = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 32'(if_valid), 32'd0);
    chk("midrst_en", 32'(mem_r_en), 32'd0);
    chk("midrst_instr", if_instr, 32'd0);
    tick();
    resetn = 1'b1;
    take("midrst_first", RST_PC);

    // Back-to-back redirects: only the last target is fetched.
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 11'd50;
    tick();
    redirect_pc = 11'd70;
    tick();
    redirect_valid = 1'b0;
    take("dbl_redir", 11'd70);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      resetn         = ($urandom_range(0, 199) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(2044, 2047))
                                                   : 11'($urandom);
      if_ready       = ($urandom_range(0, 3) != 0);
      tick();
    end
    resetn         = 1'b1;
    redirect_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
